// File: rtl/bcd_frame_ctrl.sv
// Button-gated wrapping counter with sequential shift-add-3 BCD conversion; digits commit only on a VSYNC assert edge.
// Optional button debounce is built when CTRL_DEBOUNCE_EN is defined.
module bcd_frame_ctrl #(
  parameter int unsigned MAX_COUNT = 32'd999,
  parameter int unsigned CNT_W     = 32'd10,
  parameter logic        VSYNC_POL = 1'b0
`ifdef CTRL_DEBOUNCE_EN
  ,
  parameter int unsigned DEB_CYCLES = 32'd500_000
`endif
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       TICK,
  input  logic       PBTON,
  input  logic       VSYNC,
  output logic [3:0] units,
  output logic [3:0] tens,
  output logic [3:0] hundreds,
  output logic       busy,
  output logic       upd_pulse
);

  localparam logic [1:0] S_IDLE    = 2'd0;
  localparam logic [1:0] S_CONVERT = 2'd1;
  localparam logic [1:0] S_WAIT    = 2'd2;
  localparam logic [1:0] S_COMMIT  = 2'd3;

  localparam int unsigned      STEP_W    = $clog2(CNT_W + 32'd1);
  localparam logic [STEP_W-1:0] LAST_STEP = STEP_W'(CNT_W - 32'd1);
  localparam logic [CNT_W-1:0]  MAX_C     = CNT_W'(MAX_COUNT);

  function automatic logic [3:0] add3(input logic [3:0] n);
    return (n >= 4'd5) ? (n + 4'd3) : n;
  endfunction

  // One double-dabble step: correct nibbles, then shift in the next binary bit.
  function automatic logic [11:0] dd_step(input logic [11:0] b, input logic in_bit);
    logic [11:0] adj;
    adj = {add3(b[11:8]), add3(b[7:4]), add3(b[3:0])};
    return (adj << 1) | {11'd0, in_bit};
  endfunction

  logic [1:0]        sync_q;
  logic              btn_s;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [CNT_W-1:0]  snap_q, snap_d;
  logic              dirty_q, dirty_d;
  logic [1:0]        state_q, state_d;
  logic [11:0]       bcd_q, bcd_d;
  logic [STEP_W-1:0] step_q, step_d;
  logic              vsync_q;
  logic              frame_edge_s;
  logic [3:0]        units_q, units_d, tens_q, tens_d, hund_q, hund_d;
  logic              upd_q, upd_d;
  logic              busy_q;

  // Two-flop synchronizer for the asynchronous push button.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      sync_q <= 2'b00;
    end else begin
      sync_q <= {sync_q[0], PBTON};
    end
  end

`ifdef CTRL_DEBOUNCE_EN
  localparam int unsigned      DEB_W    = $clog2(DEB_CYCLES + 32'd1);
  localparam logic [DEB_W-1:0] DEB_LAST = DEB_W'(DEB_CYCLES - 32'd1);

  logic [DEB_W-1:0] deb_q;
  logic             btn_q;

  // Debounce: accept a new level only after it has been stable for DEB_CYCLES cycles.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      deb_q <= {DEB_W{1'b0}};
      btn_q <= 1'b0;
    end else if (sync_q[1] == btn_q) begin
      deb_q <= {DEB_W{1'b0}};
    end else if (deb_q == DEB_LAST) begin
      deb_q <= {DEB_W{1'b0}};
      btn_q <= sync_q[1];
    end else begin
      deb_q <= deb_q + DEB_W'(1'b1);
    end
  end

  assign btn_s = btn_q;
`else
  assign btn_s = sync_q[1];
`endif

  assign frame_edge_s = (VSYNC == VSYNC_POL) && (vsync_q != VSYNC_POL);

  // Next-state logic for the counter and the convert/commit scheduler.
  always_comb begin
    count_d = count_q;
    snap_d  = snap_q;
    dirty_d = dirty_q;
    state_d = state_q;
    bcd_d   = bcd_q;
    step_d  = step_q;
    units_d = units_q;
    tens_d  = tens_q;
    hund_d  = hund_q;
    upd_d   = 1'b0;
    case (state_q)
      S_IDLE: begin
        if (dirty_q) begin
          state_d = S_CONVERT;
          snap_d  = count_q;
          dirty_d = 1'b0;
          bcd_d   = 12'd0;
          step_d  = {STEP_W{1'b0}};
        end else begin
          state_d = S_IDLE;
        end
      end
      S_CONVERT: begin
        bcd_d  = dd_step(bcd_q, snap_q[CNT_W-1]);
        snap_d = {snap_q[CNT_W-2:0], 1'b0};
        if (step_q == LAST_STEP) begin
          state_d = S_WAIT;
          step_d  = {STEP_W{1'b0}};
        end else begin
          step_d  = step_q + STEP_W'(1'b1);
        end
      end
      S_WAIT: begin
        if (frame_edge_s) begin
          state_d = S_COMMIT;
        end else begin
          state_d = S_WAIT;
        end
      end
      S_COMMIT: begin
        hund_d  = bcd_q[11:8];
        tens_d  = bcd_q[7:4];
        units_d = bcd_q[3:0];
        upd_d   = 1'b1;
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
    // A tick in the IDLE->CONVERT cycle must leave dirty set, so it is applied last.
    if (TICK && btn_s) begin
      count_d = (count_q == MAX_C) ? {CNT_W{1'b0}} : (count_q + CNT_W'(1'b1));
      dirty_d = 1'b1;
    end else begin
      count_d = count_q;
    end
  end

  // State, datapath and output registers.
  always_ff @(posedge CLK or posedge RST) begin
    if (RST) begin
      count_q <= {CNT_W{1'b0}};
      snap_q  <= {CNT_W{1'b0}};
      dirty_q <= 1'b0;
      state_q <= S_IDLE;
      bcd_q   <= 12'd0;
      step_q  <= {STEP_W{1'b0}};
      vsync_q <= 1'b0;
      units_q <= 4'd0;
      tens_q  <= 4'd0;
      hund_q  <= 4'd0;
      upd_q   <= 1'b0;
      busy_q  <= 1'b0;
    end else begin
      count_q <= count_d;
      snap_q  <= snap_d;
      dirty_q <= dirty_d;
      state_q <= state_d;
      bcd_q   <= bcd_d;
      step_q  <= step_d;
      vsync_q <= VSYNC;
      units_q <= units_d;
      tens_q  <= tens_d;
      hund_q  <= hund_d;
      upd_q   <= upd_d;
      busy_q  <= (state_d != S_IDLE);
    end
  end

  assign units     = units_q;
  assign tens      = tens_q;
  assign hundreds  = hund_q;
  assign upd_pulse = upd_q;
  assign busy      = busy_q;

endmodule

// File: tb/tb_bcd_frame_ctrl.sv
// Scoreboard bench for bcd_frame_ctrl: a cycle-stamped reference model predicts each commit,
// a negedge monitor checks digits, busy and pulse width against it.
module tb_bcd_frame_ctrl;

  localparam int CNT_W     = 10;
  localparam int MAX_COUNT = 999;
  localparam logic VSYNC_POL = 1'b0;
`ifdef CTRL_DEBOUNCE_EN
  localparam int SETTLE = 14;
`else
  localparam int SETTLE = 6;
`endif

  logic CLK = 1'b0;
  logic RST = 1'b1;
  logic TICK = 1'b0;
  logic PBTON = 1'b0;
  logic VSYNC = 1'b1;
  logic [3:0] units, tens, hundreds;
  logic busy, upd_pulse;

  int checks = 0;
  int errors = 0;

  bcd_frame_ctrl #(
    .MAX_COUNT(MAX_COUNT),
    .CNT_W(CNT_W),
    .VSYNC_POL(VSYNC_POL)
`ifdef CTRL_DEBOUNCE_EN
    , .DEB_CYCLES(4)
`endif
  ) dut (
    .CLK(CLK), .RST(RST), .TICK(TICK), .PBTON(PBTON), .VSYNC(VSYNC),
    .units(units), .tens(tens), .hundreds(hundreds),
    .busy(busy), .upd_pulse(upd_pulse)
  );

  always #5 CLK = ~CLK;

  function automatic logic [11:0] to_bcd(input int v);
    return {4'(v / 100), 4'((v / 10) % 10), 4'(v % 10)};
  endfunction

  // Reference model: counter value, pending-change flag and one in-flight snapshot with its frame schedule.
  int  exp_q[$];
  bit  mdl_btn = 1'b0;
  int  m_count, m_snap, m_wait_from, cyc;
  bit  m_dirty, m_inflight, m_seen, m_vs_prev;

  always @(posedge CLK or posedge RST) begin : model
    int cnt, snap, wfrom;
    bit dirty, inflight, seen;
    if (RST) begin
      m_count <= 0; m_snap <= 0; m_wait_from <= 0; cyc <= 0;
      m_dirty <= 1'b0; m_inflight <= 1'b0; m_seen <= 1'b0; m_vs_prev <= 1'b0;
      exp_q.delete();
    end else begin
      cnt = m_count; snap = m_snap; wfrom = m_wait_from;
      dirty = m_dirty; inflight = m_inflight; seen = m_seen;
      if (!inflight) begin
        if (dirty) begin
          inflight = 1'b1; snap = cnt; dirty = 1'b0;
          wfrom = cyc + CNT_W + 1;
        end
      end else if (seen) begin
        exp_q.push_back(snap);
        inflight = 1'b0; seen = 1'b0;
      end else if (cyc >= wfrom && VSYNC == VSYNC_POL && m_vs_prev != VSYNC_POL) begin
        seen = 1'b1;
      end
      if (TICK && mdl_btn) begin
        cnt = (cnt == MAX_COUNT) ? 0 : cnt + 1;
        dirty = 1'b1;
      end
      m_count <= cnt; m_snap <= snap; m_wait_from <= wfrom;
      m_dirty <= dirty; m_inflight <= inflight; m_seen <= seen;
      m_vs_prev <= VSYNC; cyc <= cyc + 1;
    end
  end

  // Monitor: compares every commit with the scoreboard and checks hold, busy and pulse width each cycle.
  logic [11:0] last_dig = 12'd0;
  bit prev_upd = 1'b0;
  always @(negedge CLK) begin : monitor
    logic [11:0] dig;
    int v;
    dig = {hundreds, tens, units};
    if (RST) begin
      checks++;
      if (dig !== 12'd0 || busy !== 1'b0 || upd_pulse !== 1'b0) begin
        errors++;
        $display("FAIL reset_state: digits=%h busy=%b upd=%b, required 000/0/0", dig, busy, upd_pulse);
      end
      last_dig = 12'd0;
      prev_upd = 1'b0;
    end else begin
      checks++;
      if (busy !== m_inflight) begin
        errors++;
        $display("FAIL busy @%0t: got %b, required %b", $time, busy, m_inflight);
      end
      if (upd_pulse === 1'b1) begin
        checks++;
        if (prev_upd) begin
          errors++;
          $display("FAIL pulse_width @%0t: upd_pulse high two cycles in a row", $time);
        end
        checks++;
        if (exp_q.size() == 0) begin
          errors++;
          $display("FAIL unexpected_update @%0t: digits=%h, no commit expected", $time, dig);
        end else begin
          v = exp_q.pop_front();
          if (dig !== to_bcd(v)) begin
            errors++;
            $display("FAIL commit_digits @%0t: got %h, required %h", $time, dig, to_bcd(v));
          end
        end
        last_dig = dig;
      end else begin
        checks++;
        if (dig !== last_dig) begin
          errors++;
          $display("FAIL digit_hold @%0t: digits %h changed to %h without upd_pulse", $time, last_dig, dig);
        end
      end
      prev_upd = (upd_pulse === 1'b1);
    end
  end

  task automatic step(input bit t, input bit v);
    @(negedge CLK);
    TICK = t;
    VSYNC = v;
  endtask

  task automatic idle(input int n);
    for (int i = 0; i < n; i++) step(1'b0, 1'b1);
  endtask

  task automatic frame();
    step(1'b0, 1'b0);
    step(1'b0, 1'b0);
    step(1'b0, 1'b1);
  endtask

  task automatic ticks(input int n);
    for (int i = 0; i < n; i++) step(1'b1, 1'b1);
    step(1'b0, 1'b1);
  endtask

  task automatic set_button(input bit v);
    @(negedge CLK);
    PBTON = v;
    TICK = 1'b0;
    idle(SETTLE);
    mdl_btn = v;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    #2 RST = 1'b1;
    TICK = 1'b0;
    repeat (2) @(negedge CLK);
    #2 RST = 1'b0;
    idle(SETTLE);
  endtask

  task automatic drain(input string nm);
    int k;
    k = 0;
    while ((m_inflight || m_dirty || exp_q.size() != 0) && k < 20) begin
      idle(CNT_W + 4);
      frame();
      idle(4);
      k++;
    end
    checks++;
    if (m_inflight || m_dirty || exp_q.size() != 0) begin
      errors++;
      $display("FAIL %s_drain: pipeline still busy after %0d frames", nm, k);
    end
  endtask

  task automatic chk_digits(input string nm, input int v);
    checks++;
    if ({hundreds, tens, units} !== to_bcd(v)) begin
      errors++;
      $display("FAIL %s: digits %h, required %h", nm, {hundreds, tens, units}, to_bcd(v));
    end
  endtask

  task automatic chk_busy(input string nm, input bit v);
    checks++;
    if (busy !== v) begin
      errors++;
      $display("FAIL %s: busy %b, required %b", nm, busy, v);
    end
  endtask

  initial begin : stim
    int vcnt, vper;
    bit t, vs;
    // 1: reset, then ten quiet frames
    do_reset();
    for (int i = 0; i < 10; i++) begin idle(20); frame(); end
    chk_digits("reset_frames", 0);
    chk_busy("reset_busy", 1'b0);

    // 2: three ticks with the button held
    set_button(1'b1);
    ticks(3);
    drain("three_ticks");
    chk_digits("three_ticks", 3);

    // 3: wrap at MAX_COUNT
    do_reset();
    ticks(999);
    drain("preload");
    chk_digits("preload_999", 999);
    ticks(1);
    drain("wrap");
    chk_digits("wrap_000", 0);
    ticks(1);
    drain("after_wrap");
    chk_digits("after_wrap_001", 1);

    // 4: released button ignores ticks
    set_button(1'b0);
    for (int i = 0; i < 5; i++) begin step(1'b1, 1'b1); idle(3); end
    idle(CNT_W + 4);
    frame();
    idle(4);
    chk_busy("released_busy", 1'b0);
    chk_digits("released_hold", 1);

    // 5: tick during the frame wait
    set_button(1'b1);
    do_reset();
    ticks(41);
    drain("to_41");
    chk_digits("value_41", 41);
    ticks(1);
    idle(CNT_W + 4);
    chk_busy("waiting_frame", 1'b1);
    step(1'b1, 1'b1);
    step(1'b0, 1'b1);
    frame();
    idle(4);
    chk_digits("inflight_42", 42);
    drain("newest");
    chk_digits("newest_43", 43);

    // 6: reset in the middle of a conversion
    do_reset();
    ticks(126);
    drain("to_126");
    chk_digits("value_126", 126);
    step(1'b1, 1'b1);
    idle(5);
    do_reset();
    chk_digits("abort_digits", 0);
    chk_busy("abort_busy", 1'b0);
    for (int i = 0; i < 3; i++) begin idle(CNT_W + 4); frame(); end
    idle(4);
    chk_digits("abort_no_commit", 0);

    // Randomized traffic: ticks, free-running frames and button changes.
    vcnt = 0;
    vper = $urandom_range(20, 60);
    for (int i = 0; i < 3000; i++) begin
      if ($urandom_range(0, 299) == 0) set_button(~mdl_btn);
      t = ($urandom_range(0, 3) == 0);
      vs = (vcnt < 2) ? VSYNC_POL : ~VSYNC_POL;
      step(t, vs);
      vcnt++;
      if (vcnt >= vper) begin
        vcnt = 0;
        vper = $urandom_range(20, 60);
      end
    end
    set_button(1'b1);
    step(1'b0, 1'b1);
    drain("random");
    idle(4);
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL leftover_expect: %0d commits never observed", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
